mcs4_rom_fetch_sequencer: RTL and testbench

- Bus master for the 4-bit MCS-4 ROM bus.
- Generates the 8-phase instruction-cycle timing: sync, clken_1/clken_2, and the phase index.
- Arbitrates between two fetch requesters (0 = CPU core, 1 = host/debug port) and drives the 12-bit ROM address as three nibbles on the shared data bus.
- Captures the returned byte from the i4001 ROM chips and returns it to the granted requester.

---
 rtl/mcs4_rom_fetch_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_mcs4_rom_fetch_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcs4_rom_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// mcs4_rom_fetch_sequencer
//
// Bus master for the 4-bit MCS-4 ROM bus. A free-running 3-bit phase counter
// steps through the eight phases of an instruction cycle (A1 A2 A3 M1 M2 X1 X2
// X3), one phase per clk. From the phase it generates sync and the two clock
// enables. At the edge that ends X3 the block picks one of two fetch
// requesters (0 = CPU core, 1 = host/debug port) and latches its 12-bit
// address. During the following A1..A3 the address goes out as three nibbles.
// The ROM's two return nibbles are captured in M1 and M2, and the assembled
// byte is handed back to the granted requester in X1.
//
// Ports
//   clk        system clock, one bus phase per clk
//   rst        synchronous, active-high reset; every output reads 0 while high
//   req_valid  per-requester fetch request, held until req_ready
//   req_addr   per-requester 12-bit fetch address, stable while requesting
//   req_ready  one-clk acceptance pulse, driven during X3
//   rsp_valid  one-clk response pulse, driven during X1 of a busy cycle
//   rsp_data   fetched byte {OPR, OPA}
//   sync       high in X3
//   clken_1    high in phases A1, A3, M2, X2
//   clken_2    high in phases A2, M1, X1, X3
//   cm_rom     ROM command line, high in A3 of a busy cycle
//   phase      current phase index, A1=0 .. X3=7
//   dbus_out   nibble driven onto the ROM bus
//   dbus_in    nibble returned by the ROM bus
// -----------------------------------------------------------------------------
module mcs4_rom_fetch_sequencer #(
  parameter bit RR_ARB = 1'b1,
  parameter int ADDR_W = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  output logic [1:0]             req_ready,
  output logic [1:0]             rsp_valid,
  output logic [7:0]             rsp_data,
  output logic                   sync,
  output logic                   clken_1,
  output logic                   clken_2,
  output logic                   cm_rom,
  output logic [2:0]             phase,
  output logic [3:0]             dbus_out,
  input  logic [3:0]             dbus_in
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_e;

  // Sequencer state
  phase_e            phase_q;
  phase_e            phase_d;
  logic              busy_q;
  logic              gid_q;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        opr_q;
  logic [3:0]        opa_q;

  // Arbitration results, meaningful only in X3
  logic              grant_d;
  logic              win_d;

  // Picks the winning requester from the sampled valid bits. A lone requester
  // always wins. On a tie, round-robin favours the requester that was not
  // granted last, and fixed priority always favours requester 0.
  function automatic logic pick_winner(input logic [1:0] valid,
                                       input logic       last);
    logic w;
    w = 1'b0;
    if (valid == 2'b10) begin
      w = 1'b1;
    end else if (valid == 2'b11) begin
      w = RR_ARB ? ~last : 1'b0;
    end
    return w;
  endfunction

  // Address nibble for the current address phase of a busy cycle
  function automatic logic [3:0] addr_nibble(input phase_e            ph,
                                             input logic [ADDR_W-1:0] a);
    logic [3:0] n;
    n = 4'd0;
    case (ph)
      PH_A1:   n = a[3:0];
      PH_A2:   n = a[7:4];
      PH_A3:   n = a[11:8];
      default: n = 4'd0;
    endcase
    return n;
  endfunction

  // The phase counter never stalls, so an idle cycle still runs all 8 phases
  assign phase_d = phase_e'(phase_q + 3'd1);
  assign win_d   = pick_winner(req_valid, last_q);
  assign grant_d = (phase_q == PH_X3) && (|req_valid);

  // ---- phase / grant / capture state ----
  // Reset parks the counter on X3, so the first clk after release shows
  // sync=1 and the ROM counters step to A1 on the same edge as ours.
  // The arbiter pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_X3;
      busy_q  <= 1'b0;
      gid_q   <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      opr_q   <= 4'd0;
      opa_q   <= 4'd0;
    end else begin
      phase_q <= phase_d;
      case (phase_q)
        PH_M1: begin
          if (busy_q) begin
            opr_q <= dbus_in;
          end
        end
        PH_M2: begin
          if (busy_q) begin
            opa_q <= dbus_in;
          end
        end
        PH_X3: begin
          // busy drops here unless a new fetch is granted on the same edge,
          // which gives back-to-back fetches one response every 8 clks
          if (grant_d) begin
            busy_q <= 1'b1;
            gid_q  <= win_d;
            last_q <= win_d;
            addr_q <= req_addr[win_d];
          end else begin
            busy_q <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---- output decode ----
  // All outputs are decodes of the registered phase and grant state (plus
  // req_valid for req_ready), forced to 0 while rst is asserted.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    rsp_data  = 8'd0;
    sync      = 1'b0;
    clken_1   = 1'b0;
    clken_2   = 1'b0;
    cm_rom    = 1'b0;
    phase     = 3'd0;
    dbus_out  = 4'd0;
    if (!rst) begin
      phase    = phase_q;
      sync     = (phase_q == PH_X3);
      clken_1  = ~phase_q[0];
      clken_2  = phase_q[0];
      rsp_data = {opr_q, opa_q};
      if (grant_d) begin
        req_ready = {win_d, ~win_d};
      end
      if (busy_q) begin
        dbus_out = addr_nibble(phase_q, addr_q);
        cm_rom   = (phase_q == PH_A3);
        if (phase_q == PH_X1) begin
          rsp_valid = {gid_q, ~gid_q};
        end
      end
    end
  end

endmodule

// File: tb/tb_mcs4_rom_fetch_sequencer.sv
module tb_mcs4_rom_fetch_sequencer;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0][11:0] req_addr = '0;
  logic [3:0]       dbus_in = 4'd0;

  logic [1:0] req_ready_r, rsp_valid_r, req_ready_f, rsp_valid_f;
  logic [7:0] rsp_data_r, rsp_data_f;
  logic       sync_r, clken_1_r, clken_2_r, cm_rom_r;
  logic       sync_f, clken_1_f, clken_2_f, cm_rom_f;
  logic [2:0] phase_r, phase_f;
  logic [3:0] dbus_out_r, dbus_out_f;

  // observed outputs: round-robin instance unless use_fp selects fixed priority
  logic       use_fp = 1'b0;
  logic [1:0] o_ready, o_rv;
  logic [7:0] o_data;
  logic       o_sync, o_ck1, o_ck2, o_cm;
  logic [2:0] o_phase;
  logic [3:0] o_dbus;

  int total = 0;
  int bad = 0;
  logic [7:0] last_byte = 8'd0;

  always #5 clk = ~clk;

  mcs4_rom_fetch_sequencer #(.RR_ARB(1'b1), .ADDR_W(12)) dut_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready_r), .rsp_valid(rsp_valid_r), .rsp_data(rsp_data_r),
    .sync(sync_r), .clken_1(clken_1_r), .clken_2(clken_2_r), .cm_rom(cm_rom_r),
    .phase(phase_r), .dbus_out(dbus_out_r), .dbus_in(dbus_in)
  );

  mcs4_rom_fetch_sequencer #(.RR_ARB(1'b0), .ADDR_W(12)) dut_fp (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready_f), .rsp_valid(rsp_valid_f), .rsp_data(rsp_data_f),
    .sync(sync_f), .clken_1(clken_1_f), .clken_2(clken_2_f), .cm_rom(cm_rom_f),
    .phase(phase_f), .dbus_out(dbus_out_f), .dbus_in(dbus_in)
  );

  assign o_ready = use_fp ? req_ready_f : req_ready_r;
  assign o_rv    = use_fp ? rsp_valid_f : rsp_valid_r;
  assign o_data  = use_fp ? rsp_data_f  : rsp_data_r;
  assign o_sync  = use_fp ? sync_f      : sync_r;
  assign o_ck1   = use_fp ? clken_1_f   : clken_1_r;
  assign o_ck2   = use_fp ? clken_2_f   : clken_2_r;
  assign o_cm    = use_fp ? cm_rom_f    : cm_rom_r;
  assign o_phase = use_fp ? phase_f     : phase_r;
  assign o_dbus  = use_fp ? dbus_out_f  : dbus_out_r;

  // Holds rst for three edges, then releases it; the bench is left in the
  // first clk after release, where phase must read X3.
  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    dbus_in = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    last_byte = 8'd0;
    #1;
  endtask

  // Runs one full instruction cycle starting from an X3 clk. nv is applied to
  // req_valid in A1; exp_rdy is the required req_ready in the closing X3.
  task automatic run_cycle(input bit busy, input bit id, input logic [11:0] addr,
                           input logic [3:0] opr, input logic [3:0] opa,
                           input logic [1:0] nv, input logic [1:0] exp_rdy,
                           input string tag);
    logic [7:0] hold;
    logic [3:0] e_dbus;
    logic [1:0] e_rv;
    logic [1:0] e_rdy;
    logic [7:0] e_data;
    hold = last_byte;
    for (int p = 0; p < 8; p++) begin
      @(posedge clk);
      #1;
      if (p == 0) req_valid = nv;
      dbus_in = (p == 3) ? opr : (p == 4) ? opa : 4'hF;
      #1;
      e_dbus = 4'd0;
      if (busy && p == 0) e_dbus = addr[3:0];
      if (busy && p == 1) e_dbus = addr[7:4];
      if (busy && p == 2) e_dbus = addr[11:8];
      e_rv   = (busy && p == 5) ? {id, ~id} : 2'b00;
      e_rdy  = (p == 7) ? exp_rdy : 2'b00;
      e_data = (busy && p >= 5) ? {opr, opa} : hold;
      total++;
      if (o_phase !== 3'(p)) begin
        bad++; $display("FAIL %s phase p%0d: got %0d want %0d", tag, p, o_phase, p);
      end
      total++;
      if (o_sync !== (p == 7)) begin
        bad++; $display("FAIL %s sync p%0d: got %b want %b", tag, p, o_sync, (p == 7));
      end
      total++;
      if (o_dbus !== e_dbus) begin
        bad++; $display("FAIL %s dbus_out p%0d: got %h want %h", tag, p, o_dbus, e_dbus);
      end
      total++;
      if (o_cm !== (busy && p == 2)) begin
        bad++; $display("FAIL %s cm_rom p%0d: got %b want %b", tag, p, o_cm, (busy && p == 2));
      end
      total++;
      if (o_rv !== e_rv) begin
        bad++; $display("FAIL %s rsp_valid p%0d: got %b want %b", tag, p, o_rv, e_rv);
      end
      total++;
      if (o_ready !== e_rdy) begin
        bad++; $display("FAIL %s req_ready p%0d: got %b want %b", tag, p, o_ready, e_rdy);
      end
      if (p != 4) begin
        total++;
        if (o_data !== e_data) begin
          bad++; $display("FAIL %s rsp_data p%0d: got %h want %h", tag, p, o_data, e_data);
        end
      end
    end
    if (busy) last_byte = {opr, opa};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({o_phase, o_sync, o_ck1, o_ck2, o_cm, o_dbus, o_rv, o_ready, o_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ph=%0d sync=%b ck1=%b ck2=%b cm=%b dbus=%h rv=%b rdy=%b data=%h want all 0",
               o_phase, o_sync, o_ck1, o_ck2, o_cm, o_dbus, o_rv, o_ready, o_data);
    end
    do_reset();
    total++;
    if (o_phase !== 3'd7 || o_sync !== 1'b1 || o_ck1 !== 1'b0 || o_ck2 !== 1'b1) begin
      bad++;
      $display("FAIL release_first_clk: got ph=%0d sync=%b ck1=%b ck2=%b want ph=7 sync=1 ck1=0 ck2=1",
               o_phase, o_sync, o_ck1, o_ck2);
    end
    for (int k = 0; k < 16; k++) begin
      logic [2:0] ep;
      ep = 3'(k);
      @(posedge clk);
      #2;
      total++;
      if (o_phase !== ep || o_sync !== (ep == 3'd7) || o_ck1 !== ~ep[0] || o_ck2 !== ep[0]
          || o_dbus !== 4'd0 || o_rv !== 2'b00) begin
        bad++;
        $display("FAIL phase_walk k%0d: got ph=%0d sync=%b ck1=%b ck2=%b dbus=%h rv=%b want ph=%0d",
                 k, o_phase, o_sync, o_ck1, o_ck2, o_dbus, o_rv, ep);
      end
    end
  endtask

  task automatic test_single_fetch();
    req_addr[0] = 12'h2A5;
    req_valid = 2'b01;
    #1;
    total++;
    if (o_ready !== 2'b01) begin
      bad++; $display("FAIL single_accept: got %b want 01", o_ready);
    end
    run_cycle(1'b1, 1'b0, 12'h2A5, 4'hC, 4'h3, 2'b00, 2'b00, "single");
    run_cycle(1'b0, 1'b0, 12'h000, 4'h5, 4'hA, 2'b00, 2'b00, "single_idle");
  endtask

  task automatic test_round_robin();
    do_reset();
    req_addr[0] = 12'h123;
    req_addr[1] = 12'h456;
    req_valid = 2'b11;
    #1;
    total++;
    if (o_ready !== 2'b01) begin
      bad++; $display("FAIL rr_first_tie: got %b want 01", o_ready);
    end
    run_cycle(1'b1, 1'b0, 12'h123, 4'h1, 4'h8, 2'b11, 2'b10, "rr0");
    run_cycle(1'b1, 1'b1, 12'h456, 4'h2, 4'h9, 2'b11, 2'b01, "rr1");
    run_cycle(1'b1, 1'b0, 12'h123, 4'h3, 4'hA, 2'b10, 2'b10, "rr2");
    run_cycle(1'b1, 1'b1, 12'h456, 4'h4, 4'hB, 2'b00, 2'b00, "rr3");
  endtask

  task automatic test_fixed_priority();
    use_fp = 1'b1;
    do_reset();
    req_addr[0] = 12'h111;
    req_addr[1] = 12'hEEF;
    req_valid = 2'b11;
    #1;
    total++;
    if (o_ready !== 2'b01) begin
      bad++; $display("FAIL fp_first_tie: got %b want 01", o_ready);
    end
    run_cycle(1'b1, 1'b0, 12'h111, 4'h6, 4'h1, 2'b11, 2'b01, "fp0");
    run_cycle(1'b1, 1'b0, 12'h111, 4'h7, 4'h2, 2'b11, 2'b01, "fp1");
    run_cycle(1'b1, 1'b0, 12'h111, 4'h8, 4'h3, 2'b10, 2'b10, "fp2");
    run_cycle(1'b1, 1'b1, 12'hEEF, 4'hD, 4'hE, 2'b00, 2'b00, "fp3");
    use_fp = 1'b0;
  endtask

  task automatic test_late_request();
    for (int p = 0; p < 7; p++) begin
      @(posedge clk);
      #1;
      if (p == 3) begin
        req_addr[0] = 12'h7C4;
        req_valid = 2'b01;
      end
      #1;
      total++;
      if (o_ready !== 2'b00 || o_dbus !== 4'd0 || o_cm !== 1'b0) begin
        bad++;
        $display("FAIL late_wait p%0d: got rdy=%b dbus=%h cm=%b want 00 0 0", p, o_ready, o_dbus, o_cm);
      end
    end
    @(posedge clk);
    #2;
    total++;
    if (o_phase !== 3'd7 || o_ready !== 2'b01) begin
      bad++; $display("FAIL late_accept: got ph=%0d rdy=%b want ph=7 rdy=01", o_phase, o_ready);
    end
    run_cycle(1'b1, 1'b0, 12'h7C4, 4'h4, 4'hE, 2'b00, 2'b00, "late");
  endtask

  task automatic test_reset_midcycle();
    req_addr[0] = 12'h9B1;
    req_addr[1] = 12'h5E2;
    req_valid = 2'b01;
    #1;
    total++;
    if (o_ready !== 2'b01) begin
      bad++; $display("FAIL mid_accept: got %b want 01", o_ready);
    end
    for (int p = 0; p < 5; p++) begin
      @(posedge clk);
      #1;
      if (p == 0) req_valid = 2'b00;
      dbus_in = (p == 3) ? 4'h6 : (p == 4) ? 4'h7 : 4'hF;
      #1;
      if (p == 0) begin
        total++;
        if (o_dbus !== 4'h1) begin
          bad++; $display("FAIL mid_a1_nibble: got %h want 1", o_dbus);
        end
      end
    end
    rst = 1'b1;
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if ({o_phase, o_sync, o_ck1, o_ck2, o_cm, o_dbus, o_rv, o_ready, o_data} !== '0) begin
        bad++;
        $display("FAIL mid_reset_out k%0d: got ph=%0d sync=%b ck1=%b ck2=%b cm=%b dbus=%h rv=%b rdy=%b data=%h want all 0",
                 k, o_phase, o_sync, o_ck1, o_ck2, o_cm, o_dbus, o_rv, o_ready, o_data);
      end
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    last_byte = 8'd0;
    #1;
    total++;
    if (o_phase !== 3'd7 || o_sync !== 1'b1 || o_rv !== 2'b00) begin
      bad++; $display("FAIL mid_resync: got ph=%0d sync=%b rv=%b want 7 1 00", o_phase, o_sync, o_rv);
    end
    total++;
    if (o_ready !== 2'b01) begin
      bad++; $display("FAIL mid_ptr_reset: got %b want 01", o_ready);
    end
    run_cycle(1'b1, 1'b0, 12'h9B1, 4'h3, 4'hC, 2'b10, 2'b10, "post_rst0");
    run_cycle(1'b1, 1'b1, 12'h5E2, 4'hB, 4'h2, 2'b00, 2'b00, "post_rst1");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_fixed_priority();
    test_late_request();
    test_reset_midcycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
